mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 43 ++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared defaults and types for the fetch/data memory arbiter.
// Build option MEM_ARB_RR_EN is consumed by mem_arb_pick.
package mem_arb_pkg;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int MEM_TOP = 256;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    typedef enum logic {
        PORT_F,
        PORT_D
    } port_t;

    function automatic port_t other_port(port_t p);
        return (p == PORT_D) ? PORT_F : PORT_D;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Port select for the arbiter: combinational pick plus the tie-break pointer.
// Define MEM_ARB_RR_EN for round-robin ties; default build lets the data port win ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic i_f_req,
    input  logic i_d_req,
    input  logic i_take,
    output logic o_any,
    output logic o_sel_d
);

    port_t r_ptr;
    port_t w_sel;

    always_comb begin
        w_sel = PORT_F;
        if (i_f_req && i_d_req) begin
            w_sel = r_ptr;
        end else if (i_d_req) begin
            w_sel = PORT_D;
        end
    end

    assign o_any   = i_f_req | i_d_req;
    assign o_sel_d = (w_sel == PORT_D);

    // In fixed-priority builds the pointer is pinned to the data port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr <= PORT_D;
        end else if (i_take) begin
`ifdef MEM_ARB_RR_EN
            r_ptr <= other_port(w_sel);
`else
            r_ptr <= PORT_D;
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data two-port arbiter onto a single registered-read memory, one transaction in flight.
// Build option: define MEM_ARB_RR_EN for round-robin ties (default: data port wins ties).
module mem_arbiter #(
    parameter int ADDR_W  = mem_arb_pkg::ADDR_W,
    parameter int DATA_W  = mem_arb_pkg::DATA_W,
    parameter int MEM_TOP = mem_arb_pkg::MEM_TOP
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_val,
    output logic              addr_err
);
    import mem_arb_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_TOP);

    state_t            r_state;
    port_t             r_sel;
    logic              r_we;
    logic              r_err;
    logic              r_f_gnt;
    logic              r_d_gnt;
    logic              r_f_valid;
    logic              r_d_valid;
    logic              r_addr_err;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    logic [DATA_W-1:0] r_f_hold;
    logic [DATA_W-1:0] r_d_hold;

    logic              w_any;
    logic              w_sel_d;
    logic              w_take;
    logic              w_we;
    logic              w_err;
    port_t             w_sel;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_f_rdata;
    logic [DATA_W-1:0] w_d_rdata;

    mem_arb_pick u_pick (
        .clock   (clock),
        .reset   (reset),
        .i_f_req (f_req),
        .i_d_req (d_req),
        .i_take  (w_take),
        .o_any   (w_any),
        .o_sel_d (w_sel_d)
    );

    assign w_take  = w_any && (r_state != ISSUE);
    assign w_sel   = w_sel_d ? PORT_D : PORT_F;
    assign w_addr  = w_sel_d ? d_addr : f_addr;
    assign w_wdata = w_sel_d ? d_wdata : '0;
    assign w_we    = w_sel_d & d_we;
    assign w_err   = (w_addr > LAST_ADDR);

    // mem_val is only meaningful during RESP, so rdata bypasses it then and holds afterwards.
    assign w_f_rdata = r_addr_err ? '0 : mem_val;
    assign w_d_rdata = r_addr_err ? '0 : (r_we ? r_d_hold : mem_val);
    assign f_rdata   = r_f_valid ? w_f_rdata : r_f_hold;
    assign d_rdata   = r_d_valid ? w_d_rdata : r_d_hold;

    assign f_gnt     = r_f_gnt;
    assign d_gnt     = r_d_gnt;
    assign f_valid   = r_f_valid;
    assign d_valid   = r_d_valid;
    assign addr_err  = r_addr_err;
    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;
    assign mem_write = r_mem_write;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_sel       <= PORT_F;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_f_gnt     <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_f_valid   <= 1'b0;
            r_d_valid   <= 1'b0;
            r_addr_err  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_f_hold    <= '0;
            r_d_hold    <= '0;
        end else begin
            r_f_gnt     <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_f_valid   <= 1'b0;
            r_d_valid   <= 1'b0;
            r_addr_err  <= 1'b0;
            r_mem_write <= 1'b0;

            case (r_state)
                IDLE:    r_state <= w_any ? ISSUE : IDLE;
                ISSUE: begin
                    r_f_valid  <= (r_sel == PORT_F);
                    r_d_valid  <= (r_sel == PORT_D);
                    r_addr_err <= r_err;
                    r_state    <= RESP;
                end
                RESP:    r_state <= w_any ? ISSUE : IDLE;
                default: r_state <= IDLE;
            endcase

            if (r_f_valid) r_f_hold <= w_f_rdata;
            if (r_d_valid) r_d_hold <= w_d_rdata;

            // Selection in IDLE or RESP: capture the winner and issue it next cycle.
            if (w_take) begin
                r_sel       <= w_sel;
                r_we        <= w_we;
                r_err       <= w_err;
                r_mem_addr  <= w_addr;
                r_mem_din   <= w_wdata;
                r_mem_write <= w_we & ~w_err;
                r_f_gnt     <= ~w_sel_d;
                r_d_gnt     <= w_sel_d;
            end
        end
    end

endmodule
